// File: rtl/pattern_tx.sv
// pattern_tx -- parallel-to-serial frame transmitter with a built-in
// reference pattern checker.
//
// A WIDTH-bit frame is taken on a load_valid/load_ready handshake and
// shifted out MSB first on w, one bit per clock. A frame offered while the
// last bit is on w follows it with no gap cycle. In parallel, a 2-bit history
// of w (sampled every cycle, IDLE zeros included) is matched against the
// patterns 110 and 101. exp_hit flags the cycle in which the current w bit
// completes a match, and hit_cnt counts those cycles and saturates at 255.
//
// Ports
//   clk         in   rising-edge clock
//   clr         in   asynchronous, active-low reset
//   load_valid  in   a parallel frame is offered
//   load_data   in   frame to send, MSB first (WIDTH bits)
//   load_ready  out  a frame can be accepted this cycle
//   w           out  registered serial bit stream
//   w_valid     out  w carries a frame bit
//   busy        out  a frame is in progress
//   done        out  high while the last bit of a frame is on w
//   exp_hit     out  the current w bit completes 110 or 101
//   hit_cnt     out  saturating count of exp_hit cycles (8 bits)
module pattern_tx #(
  parameter int WIDTH = 8
) (
  input  logic             clk,
  input  logic             clr,
  input  logic             load_valid,
  input  logic [WIDTH-1:0] load_data,
  output logic             load_ready,
  output logic             w,
  output logic             w_valid,
  output logic             busy,
  output logic             done,
  output logic             exp_hit,
  output logic [7:0]       hit_cnt
);

  localparam int CW = (WIDTH > 1) ? $clog2(WIDTH) : 1;
  // Index of the last bit of a frame; WIDTH-1 always fits in CW bits.
  localparam logic [CW-1:0] LAST = CW'(WIDTH - 1);

  typedef enum logic {
    IDLE  = 1'b0,
    SHIFT = 1'b1
  } state_t;

  state_t           state_q, state_d;
  logic [WIDTH-1:0] shreg_q, shreg_d;
  logic [CW-1:0]    cnt_q, cnt_d;
  logic             w_q, w_d;
  logic             w_valid_q, w_valid_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [1:0]       hist_q, hist_d;
  logic [7:0]       hit_cnt_q, hit_cnt_d;
  logic             accept;
  logic             match;

  // Ready in IDLE and during the last bit, so a new frame can follow the
  // current one directly. Gated by clr so it stays low throughout reset.
  assign load_ready = clr & ((state_q == IDLE) | done_q);
  assign accept     = load_valid & load_ready;

  // Match against the two previous w values (oldest first) plus current w.
  assign match = ({hist_q, w_q} == 3'b110) | ({hist_q, w_q} == 3'b101);

  always_comb begin
    state_d   = state_q;
    shreg_d   = shreg_q;
    cnt_d     = cnt_q;
    w_d       = 1'b0;
    w_valid_d = 1'b0;
    busy_d    = 1'b0;
    done_d    = 1'b0;

    if (accept) begin
      // MSB goes straight onto w; the remaining bits wait in the shifter.
      state_d   = SHIFT;
      w_d       = load_data[WIDTH-1];
      shreg_d   = {load_data[WIDTH-2:0], 1'b0};
      cnt_d     = '0;
      w_valid_d = 1'b1;
      busy_d    = 1'b1;
    end else if ((state_q == SHIFT) && !done_q) begin
      w_d       = shreg_q[WIDTH-1];
      shreg_d   = {shreg_q[WIDTH-2:0], 1'b0};
      cnt_d     = cnt_q + 1'b1;
      w_valid_d = 1'b1;
      busy_d    = 1'b1;
      done_d    = (cnt_d == LAST);
    end else begin
      // Last bit sent with no follow-on frame, or already idle.
      state_d = IDLE;
      cnt_d   = '0;
    end

    // The history keeps sampling in IDLE, just as a free-running detector.
    hist_d = {hist_q[0], w_q};

    hit_cnt_d = hit_cnt_q;
    if (match && (hit_cnt_q != 8'hFF)) begin
      hit_cnt_d = hit_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk or negedge clr) begin
    if (!clr) begin
      state_q   <= IDLE;
      shreg_q   <= '0;
      cnt_q     <= '0;
      w_q       <= 1'b0;
      w_valid_q <= 1'b0;
      busy_q    <= 1'b0;
      done_q    <= 1'b0;
      hist_q    <= 2'b00;
      hit_cnt_q <= 8'd0;
    end else begin
      state_q   <= state_d;
      shreg_q   <= shreg_d;
      cnt_q     <= cnt_d;
      w_q       <= w_d;
      w_valid_q <= w_valid_d;
      busy_q    <= busy_d;
      done_q    <= done_d;
      hist_q    <= hist_d;
      hit_cnt_q <= hit_cnt_d;
    end
  end

  assign w       = w_q;
  assign w_valid = w_valid_q;
  assign busy    = busy_q;
  assign done    = done_q;
  assign exp_hit = match;
  assign hit_cnt = hit_cnt_q;

endmodule

// File: tb/tb_pattern_tx.sv
module tb_pattern_tx;

  logic       clk;
  logic       clr;
  logic       load_valid;
  logic [7:0] load_data;
  logic       load_ready;
  logic       w;
  logic       w_valid;
  logic       busy;
  logic       done;
  logic       exp_hit;
  logic [7:0] hit_cnt;

  int checks;
  int failures;
  int exp_cnt;

  pattern_tx #(.WIDTH(8)) dut (
    .clk        (clk),
    .clr        (clr),
    .load_valid (load_valid),
    .load_data  (load_data),
    .load_ready (load_ready),
    .w          (w),
    .w_valid    (w_valid),
    .busy       (busy),
    .done       (done),
    .exp_hit    (exp_hit),
    .hit_cnt    (hit_cnt)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Registered sequence detector fed by w, as downstream logic would see it.
  logic [1:0] det_sh;
  logic       det_out;
  always @(posedge clk or negedge clr) begin
    if (!clr) begin
      det_sh  <= 2'b00;
      det_out <= 1'b0;
    end else begin
      det_sh  <= {det_sh[0], w};
      det_out <= ({det_sh, w} == 3'b110) || ({det_sh, w} == 3'b101);
    end
  end

  task automatic test_reset();
    clr        = 1'b0;
    load_valid = 1'b1;
    load_data  = 8'hB6;
    repeat (2) @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done, exp_hit, load_ready} !== 6'b0) begin
      failures++;
      $display("FAIL reset_outputs got=%b want=000000",
               {w, w_valid, busy, done, exp_hit, load_ready});
    end
    checks++;
    if (hit_cnt !== 8'd0) begin
      failures++;
      $display("FAIL reset_hit_cnt got=%0d want=0", hit_cnt);
    end
    load_valid = 1'b0;
    clr        = 1'b1;
    @(negedge clk);
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL reset_ready_rise got=%b want=1", load_ready);
    end
    checks++;
    if ({w, w_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL reset_idle got=%b want=000", {w, w_valid, busy});
    end
    exp_cnt = 0;
    $display("reset: checked outputs during and after clr");
  endtask

  // Load 0xB6 from an idle line (history 00) and check the full response.
  task automatic test_basic_b6();
    logic [7:0] pat;
    logic [7:0] hmask;
    pat   = 8'hB6;
    hmask = 8'hB4;  // hits on cycles 3,5,6,8
    @(negedge clk);
    load_valid = 1'b1;
    load_data  = pat;
    checks++;
    if (load_ready !== 1'b1) begin
      failures++;
      $display("FAIL basic_ready_idle got=%b want=1", load_ready);
    end
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    load_data  = 8'h00;
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (w !== pat[8-i]) begin
        failures++;
        $display("FAIL basic_w cycle=%0d got=%b want=%b", i, w, pat[8-i]);
      end
      checks++;
      if ({w_valid, busy} !== 2'b11) begin
        failures++;
        $display("FAIL basic_valid_busy cycle=%0d got=%b want=11", i, {w_valid, busy});
      end
      checks++;
      if (exp_hit !== hmask[i-1]) begin
        failures++;
        $display("FAIL basic_exp_hit cycle=%0d got=%b want=%b", i, exp_hit, hmask[i-1]);
      end
      checks++;
      if (done !== (i == 8)) begin
        failures++;
        $display("FAIL basic_done cycle=%0d got=%b want=%b", i, done, (i == 8));
      end
      checks++;
      if (load_ready !== (i == 8)) begin
        failures++;
        $display("FAIL basic_ready cycle=%0d got=%b want=%b", i, load_ready, (i == 8));
      end
    end
    exp_cnt += 4;
    @(negedge clk);
    checks++;
    if ({w, w_valid, busy, done, load_ready} !== 5'b00001) begin
      failures++;
      $display("FAIL basic_idle got=%b want=00001", {w, w_valid, busy, done, load_ready});
    end
    checks++;
    if (hit_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL basic_hit_cnt got=%0d want=%0d", hit_cnt, exp_cnt);
    end
    $display("basic: frame 0xB6 sent, hit_cnt=%0d", hit_cnt);
  endtask

  // 0xFF then 0x00 taken in the done cycle: 16 contiguous bits, one hit.
  task automatic test_back_to_back();
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_data  = 8'hFF;
    @(posedge clk);
    #1;
    load_data = 8'h00;
    for (int i = 1; i <= 16; i++) begin
      @(negedge clk);
      checks++;
      if (w !== (i <= 8)) begin
        failures++;
        $display("FAIL b2b_w cycle=%0d got=%b want=%b", i, w, (i <= 8));
      end
      checks++;
      if ({w_valid, busy} !== 2'b11) begin
        failures++;
        $display("FAIL b2b_valid cycle=%0d got=%b want=11", i, {w_valid, busy});
      end
      checks++;
      if (exp_hit !== (i == 9)) begin
        failures++;
        $display("FAIL b2b_exp_hit cycle=%0d got=%b want=%b", i, exp_hit, (i == 9));
      end
      checks++;
      if (done !== ((i == 8) || (i == 16))) begin
        failures++;
        $display("FAIL b2b_done cycle=%0d got=%b want=%b", i, done, ((i == 8) || (i == 16)));
      end
      if (i == 9) load_valid = 1'b0;
    end
    exp_cnt += 1;
    @(negedge clk);
    checks++;
    if ({w, w_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL b2b_idle got=%b want=000", {w, w_valid, busy});
    end
    checks++;
    if (hit_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL b2b_hit_cnt got=%0d want=%0d", hit_cnt, exp_cnt);
    end
    $display("back_to_back: 0xFF,0x00 sent, hit_cnt=%0d", hit_cnt);
  endtask

  // load_valid held with changing data mid-frame must not disturb it.
  task automatic test_hold_valid();
    logic [7:0] pat;
    logic [7:0] hmask;
    pat   = 8'h3C;
    hmask = 8'h40;  // single hit on cycle 7 (110)
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_data  = pat;
    @(posedge clk);
    #1;
    load_data = 8'($urandom);
    for (int i = 1; i <= 8; i++) begin
      @(negedge clk);
      checks++;
      if (w !== pat[8-i]) begin
        failures++;
        $display("FAIL hold_w cycle=%0d got=%b want=%b", i, w, pat[8-i]);
      end
      checks++;
      if (load_ready !== (i == 8)) begin
        failures++;
        $display("FAIL hold_ready cycle=%0d got=%b want=%b", i, load_ready, (i == 8));
      end
      checks++;
      if (exp_hit !== hmask[i-1]) begin
        failures++;
        $display("FAIL hold_exp_hit cycle=%0d got=%b want=%b", i, exp_hit, hmask[i-1]);
      end
      if (i < 8) load_data = 8'($urandom);
      else       load_valid = 1'b0;
    end
    exp_cnt += 1;
    @(negedge clk);
    checks++;
    if ({w_valid, busy} !== 2'b00) begin
      failures++;
      $display("FAIL hold_idle got=%b want=00", {w_valid, busy});
    end
    checks++;
    if (hit_cnt !== 8'(exp_cnt)) begin
      failures++;
      $display("FAIL hold_hit_cnt got=%0d want=%0d", hit_cnt, exp_cnt);
    end
    $display("hold_valid: 0x3C sent under changing data, hit_cnt=%0d", hit_cnt);
  endtask

  // clr mid-frame clears outputs at once; a fresh 0xB6 then behaves as new.
  task automatic test_abort();
    logic [7:0] pat;
    pat = 8'hB6;
    repeat (3) @(negedge clk);
    load_valid = 1'b1;
    load_data  = pat;
    @(posedge clk);
    #1;
    load_valid = 1'b0;
    for (int i = 1; i <= 3; i++) begin
      @(negedge clk);
      checks++;
      if (w !== pat[8-i]) begin
        failures++;
        $display("FAIL abort_pre_w cycle=%0d got=%b want=%b", i, w, pat[8-i]);
      end
    end
    #2;
    clr = 1'b0;
    #1;
    checks++;
    if ({w, w_valid, busy, done, exp_hit, load_ready} !== 6'b0) begin
      failures++;
      $display("FAIL abort_async_outputs got=%b want=000000",
               {w, w_valid, busy, done, exp_hit, load_ready});
    end
    checks++;
    if (hit_cnt !== 8'd0) begin
      failures++;
      $display("FAIL abort_hit_cnt got=%0d want=0", hit_cnt);
    end
    exp_cnt = 0;
    @(posedge clk);
    @(negedge clk);
    clr = 1'b1;
    @(negedge clk);
    checks++;
    if ({load_ready, w, busy} !== 3'b100) begin
      failures++;
      $display("FAIL abort_no_resume got=%b want=100", {load_ready, w, busy});
    end
    $display("abort: clr mid-frame cleared outputs, reloading 0xB6");
    test_basic_b6();
  endtask

  // Free-running check of exp_hit against the observed w stream, and of the
  // registered detector's pulse one cycle after every exp_hit.
  task automatic test_detector();
    logic [1:0] obs_hist;
    logic       prev_hit;
    logic       want_hit;
    int         hits_seen;
    hits_seen = 0;
    repeat (2) @(negedge clk);
    @(negedge clk);
    obs_hist[1] = w;
    @(negedge clk);
    obs_hist[0] = w;
    prev_hit    = exp_hit;
    load_valid  = 1'b1;
    load_data   = 8'($urandom);
    for (int i = 1; i <= 44; i++) begin
      @(negedge clk);
      want_hit = ({obs_hist, w} == 3'b110) || ({obs_hist, w} == 3'b101);
      checks++;
      if (exp_hit !== want_hit) begin
        failures++;
        $display("FAIL det_exp_hit cycle=%0d got=%b want=%b", i, exp_hit, want_hit);
      end
      checks++;
      if (det_out !== prev_hit) begin
        failures++;
        $display("FAIL det_out_align cycle=%0d got=%b want=%b", i, det_out, prev_hit);
      end
      if (exp_hit === 1'b1) hits_seen++;
      prev_hit = exp_hit;
      obs_hist = {obs_hist[0], w};
      if (i < 30) load_data = 8'($urandom);
      else        load_valid = 1'b0;
    end
    $display("detector: 44 cycles compared, %0d hits seen", hits_seen);
  endtask

  // 64 contiguous 0xAA frames drive hit_cnt to 255; a 65th must not wrap it.
  task automatic test_saturate();
    logic [7:0] pat;
    logic [7:0] m_first;
    logic [7:0] m_rest;
    logic       want_hit;
    int         bitpos;
    pat     = 8'hAA;
    m_first = 8'h54;  // cycles 3,5,7
    m_rest  = 8'h55;  // cycles 1,3,5,7
    @(negedge clk);
    clr = 1'b0;
    @(negedge clk);
    clr = 1'b1;
    repeat (2) @(negedge clk);
    load_valid = 1'b1;
    load_data  = pat;
    @(posedge clk);
    for (int i = 1; i <= 520; i++) begin
      @(negedge clk);
      bitpos   = (i - 1) % 8;
      want_hit = (i <= 8) ? m_first[bitpos] : m_rest[bitpos];
      checks++;
      if ({w, w_valid} !== {pat[7-bitpos], 1'b1}) begin
        failures++;
        $display("FAIL sat_w cycle=%0d got=%b want=%b", i, {w, w_valid}, {pat[7-bitpos], 1'b1});
      end
      checks++;
      if (exp_hit !== want_hit) begin
        failures++;
        $display("FAIL sat_exp_hit cycle=%0d got=%b want=%b", i, exp_hit, want_hit);
      end
      if (i == 505) begin
        checks++;
        if (hit_cnt !== 8'd251) begin
          failures++;
          $display("FAIL sat_cnt_frame64 got=%0d want=251", hit_cnt);
        end
      end
      if (i == 512) begin
        checks++;
        if (hit_cnt !== 8'd255) begin
          failures++;
          $display("FAIL sat_cnt_reach got=%0d want=255", hit_cnt);
        end
      end
      if (i == 520) load_valid = 1'b0;
    end
    @(negedge clk);
    checks++;
    if (hit_cnt !== 8'd255) begin
      failures++;
      $display("FAIL sat_cnt_hold got=%0d want=255", hit_cnt);
    end
    checks++;
    if ({w, w_valid, busy} !== 3'b000) begin
      failures++;
      $display("FAIL sat_idle got=%b want=000", {w, w_valid, busy});
    end
    $display("saturate: 65 frames of 0xAA sent, hit_cnt=%0d", hit_cnt);
  endtask

  initial begin
    checks     = 0;
    failures   = 0;
    exp_cnt    = 0;
    clr        = 1'b0;
    load_valid = 1'b0;
    load_data  = 8'h00;
    test_reset();
    test_basic_b6();
    test_back_to_back();
    test_hold_valid();
    test_abort();
    test_detector();
    test_saturate();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
